// File: rtl/mem_req_initiator.sv
// mem_req_initiator: turns a valid/ready command stream into registered memory-pin activity and buffers read responses
module mem_req_initiator #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              mem_wr_rdn,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = PW + 2;
    localparam logic [OW-1:0] DEPTH_O = OW'(RSP_DEPTH);

    logic [DATA_W-1:0] fifo_data [RSP_DEPTH];
    logic [ADDR_W-1:0] fifo_addr [RSP_DEPTH];
    logic [PW-1:0]     wp, rp;
    logic [CW-1:0]     cnt, cnt_nx;
    logic [OW-1:0]     occ_nx;
    logic              p1_vld, p2_vld;
    logic [ADDR_W-1:0] p1_addr, p2_addr;
    logic              rdy_q;
    logic              acc, acc_rd, push, pop;

    assign cmd_ready = rdy_q;

    // Handshakes and the occupancy the next cycle will see (buffered plus still in the read pipe)
    always_comb begin
        acc       = cmd_valid & rdy_q;
        acc_rd    = acc & ~cmd_wr;
        push      = p2_vld;
        rsp_valid = cnt != '0;
        pop       = rsp_valid & rsp_ready;
        cnt_nx    = cnt + CW'(push) - CW'(pop);
        occ_nx    = OW'(cnt_nx) + OW'(acc_rd) + OW'(p1_vld);
        rsp_rdata = rsp_valid ? fifo_data[rp] : '0;
        rsp_addr  = rsp_valid ? fifo_addr[rp] : '0;
    end

    // Memory pins: a command is presented for one cycle, idle cycles fall back to a harmless read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wr_rdn <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            mem_wr_rdn <= acc & cmd_wr;
            if (acc) mem_addr <= cmd_addr;
            if (acc & cmd_wr) mem_wdata <= cmd_wdata;
        end
    end

    // Read tracking: stage 1 while the memory samples, stage 2 while its data is on mem_rdata
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_vld  <= 1'b0;
            p2_vld  <= 1'b0;
            p1_addr <= '0;
            p2_addr <= '0;
        end else begin
            p1_vld  <= acc_rd;
            p2_vld  <= p1_vld;
            if (acc_rd) p1_addr <= cmd_addr;
            p2_addr <= p1_addr;
        end
    end

    // FIFO pointers, count, and admission; ready is the registered view of next-cycle occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            cnt   <= '0;
            rdy_q <= 1'b0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            cnt   <= cnt_nx;
            rdy_q <= occ_nx < DEPTH_O;
        end
    end

    // FIFO storage; stale entries are never visible because the outputs are gated by rsp_valid
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wp] <= mem_rdata;
            fifo_addr[wp] <= p2_addr;
        end
    end

endmodule

// File: tb/tb_mem_req_initiator.sv
// tb_mem_req_initiator: directed table, corner sequences and random traffic against a transaction-level model
module tb_mem_req_initiator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_wr;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_rdata;
    logic [3:0] rsp_addr;
    logic       mem_wr_rdn;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    mem_req_initiator #(.ADDR_W(4), .DATA_W(8), .RSP_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_addr(rsp_addr),
        .mem_wr_rdn(mem_wr_rdn), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Register-file memory: write commits on the edge, read data registered, out_data 0 after a write
    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (mem_wr_rdn) begin
            mem[mem_addr] <= mem_wdata;
            mem_rdata     <= 8'h00;
        end else begin
            mem_rdata <= mem[mem_addr];
        end
    end

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
        int         due;
    } exp_t;

    typedef struct {
        logic       v, w;
        logic [3:0] a;
        logic [7:0] d;
        logic       rr;
        logic       e_rdy, e_rv;
        logic [7:0] e_rd;
        logic [3:0] e_ra;
        logic       e_mw;
        logic [3:0] e_ma;
        logic [7:0] e_md;
    } vec_t;

    exp_t       q[$];
    logic [7:0] shadow [16];
    logic       m_mw, m_ready;
    logic [3:0] m_ma;
    logic [7:0] m_md;
    int         cyc;
    int         total = 0;
    int         bad = 0;
    logic       acc;
    vec_t       tbl [16];

    function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
        end
    endfunction

    function automatic logic m_rv();
        return q.size() > 0 && q[0].due <= cyc;
    endfunction

    task automatic check_all();
        chk("cmd_ready", 32'(cmd_ready), 32'(m_ready));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_rv()));
        if (m_rv()) begin
            chk("rsp_rdata", 32'(rsp_rdata), 32'(q[0].d));
            chk("rsp_addr", 32'(rsp_addr), 32'(q[0].a));
        end
        chk("mem_wr_rdn", 32'(mem_wr_rdn), 32'(m_mw));
        chk("mem_addr", 32'(mem_addr), 32'(m_ma));
        chk("mem_wdata", 32'(mem_wdata), 32'(m_md));
    endtask

    task automatic set_in(input logic v, input logic w, input logic [3:0] a, input logic [7:0] d, input logic rr);
        cmd_valid = v;
        cmd_wr    = w;
        cmd_addr  = a;
        cmd_wdata = d;
        rsp_ready = rr;
    endtask

    // One clock: drive at the falling edge, advance the model at the rising edge, check at the next falling edge
    task automatic tick(input logic v, input logic w, input logic [3:0] a, input logic [7:0] d, input logic rr, output logic ac);
        logic pop;
        set_in(v, w, a, d, rr);
        ac  = v && m_ready;
        pop = m_rv() && rr;
        @(posedge clk);
        cyc++;
        if (pop) void'(q.pop_front());
        m_mw = ac && w;
        if (ac) m_ma = a;
        if (ac && w) begin
            m_md      = d;
            shadow[a] = d;
        end
        if (ac && !w) q.push_back('{a, shadow[a], cyc + 2});
        m_ready = q.size() < 4;
        @(negedge clk);
        check_all();
    endtask

    task automatic reset_checks();
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
        chk("rst_rsp_addr", 32'(rsp_addr), 0);
        chk("rst_mem_wr_rdn", 32'(mem_wr_rdn), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0);
        q.delete();
        m_mw    = 1'b0;
        m_ma    = 4'h0;
        m_md    = 8'h00;
        m_ready = 1'b0;
        #1;
        reset_checks();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n, k, npop;
        logic       seen;
        logic [7:0] fv;
        logic [3:0] got [6];

        tbl[0]  = '{1, 1, 4'd3, 8'hA5, 1, 1, 0, 8'h00, 4'd0, 1, 4'd3, 8'hA5};
        tbl[1]  = '{1, 0, 4'd3, 8'h00, 1, 1, 0, 8'h00, 4'd0, 0, 4'd3, 8'hA5};
        tbl[2]  = '{0, 0, 4'd0, 8'h00, 1, 1, 0, 8'h00, 4'd0, 0, 4'd3, 8'hA5};
        tbl[3]  = '{0, 0, 4'd0, 8'h00, 1, 1, 1, 8'hA5, 4'd3, 0, 4'd3, 8'hA5};
        tbl[4]  = '{0, 0, 4'd0, 8'h00, 1, 1, 0, 8'h00, 4'd0, 0, 4'd3, 8'hA5};
        tbl[5]  = '{1, 1, 4'd0, 8'h10, 1, 1, 0, 8'h00, 4'd0, 1, 4'd0, 8'h10};
        tbl[6]  = '{1, 1, 4'd1, 8'h21, 1, 1, 0, 8'h00, 4'd0, 1, 4'd1, 8'h21};
        tbl[7]  = '{1, 1, 4'd2, 8'h32, 1, 1, 0, 8'h00, 4'd0, 1, 4'd2, 8'h32};
        tbl[8]  = '{1, 1, 4'd3, 8'h43, 1, 1, 0, 8'h00, 4'd0, 1, 4'd3, 8'h43};
        tbl[9]  = '{1, 0, 4'd0, 8'h00, 1, 1, 0, 8'h00, 4'd0, 0, 4'd0, 8'h43};
        tbl[10] = '{1, 0, 4'd1, 8'h00, 1, 1, 0, 8'h00, 4'd0, 0, 4'd1, 8'h43};
        tbl[11] = '{1, 0, 4'd2, 8'h00, 1, 1, 1, 8'h10, 4'd0, 0, 4'd2, 8'h43};
        tbl[12] = '{1, 0, 4'd3, 8'h00, 1, 1, 1, 8'h21, 4'd1, 0, 4'd3, 8'h43};
        tbl[13] = '{0, 0, 4'd0, 8'h00, 1, 1, 1, 8'h32, 4'd2, 0, 4'd3, 8'h43};
        tbl[14] = '{0, 0, 4'd0, 8'h00, 1, 1, 1, 8'h43, 4'd3, 0, 4'd3, 8'h43};
        tbl[15] = '{0, 0, 4'd0, 8'h00, 1, 1, 0, 8'h00, 4'd0, 0, 4'd3, 8'h43};

        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0);
        m_mw = 1'b0; m_ma = 4'h0; m_md = 8'h00; m_ready = 1'b0; cyc = 0;
        @(negedge clk);
        reset_checks();
        @(negedge clk);
        rst_n = 1'b1;
        tick(0, 0, 0, 0, 1, acc);

        for (int i = 0; i < 16; i++) begin
            tick(tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].rr, acc);
            chk("tbl_ready", 32'(cmd_ready), 32'(tbl[i].e_rdy));
            chk("tbl_rsp_valid", 32'(rsp_valid), 32'(tbl[i].e_rv));
            if (tbl[i].e_rv) begin
                chk("tbl_rsp_rdata", 32'(rsp_rdata), 32'(tbl[i].e_rd));
                chk("tbl_rsp_addr", 32'(rsp_addr), 32'(tbl[i].e_ra));
            end
            chk("tbl_mem_wr_rdn", 32'(mem_wr_rdn), 32'(tbl[i].e_mw));
            chk("tbl_mem_addr", 32'(mem_addr), 32'(tbl[i].e_ma));
            chk("tbl_mem_wdata", 32'(mem_wdata), 32'(tbl[i].e_md));
        end

        n = 0;
        for (int i = 0; i < 8; i++) begin
            chk("wo_ready", 32'(cmd_ready), 1);
            tick(1, 1, 4'(4 + i), 8'(8'h60 + i), 1, acc);
            chk("wo_pin_addr", 32'(mem_addr), 32'(4 + i));
            chk("wo_pin_data", 32'(mem_wdata), 32'(8'h60 + i));
            if (rsp_valid) n++;
        end
        chk("wo_rsp_count", 32'(n), 0);
        for (int i = 12; i < 16; i++) tick(1, 1, 4'(i), 8'(8'h70 + i), 1, acc);
        tick(0, 0, 0, 0, 1, acc);

        k = 0;
        seen = 1'b0;
        fv = 8'h00;
        for (int c = 0; c < 10; c++) begin
            tick(k < 6, 0, 4'(k), 0, 0, acc);
            if (acc) begin
                k++;
                if (k == 4) chk("bp_ready_drop", 32'(cmd_ready), 0);
            end
            if (rsp_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    fv = rsp_rdata;
                end else chk("bp_hold", 32'(rsp_rdata), 32'(fv));
            end
        end
        chk("bp_accepts", 32'(k), 4);
        chk("bp_first_data", 32'(fv), 32'h10);
        npop = 0;
        for (int c = 0; c < 40 && npop < 6; c++) begin
            if (rsp_valid) begin
                got[npop] = rsp_addr;
                npop++;
            end
            tick(k < 6, 0, 4'(k), 0, 1, acc);
            if (acc) k++;
        end
        chk("bp_rsp_count", 32'(npop), 6);
        for (int j = 0; j < 6; j++) chk("bp_order", 32'(got[j]), 32'(j));

        for (int i = 0; i < 3; i++) tick(1, 0, 4'(i), 0, 0, acc);
        chk("mid_rsp_pending", 32'(rsp_valid), 1);
        do_reset();
        n = 0;
        for (int c = 0; c < 8; c++) begin
            tick(0, 0, 0, 0, 1, acc);
            if (rsp_valid) n++;
        end
        chk("rst_no_stale", 32'(n), 0);
        tick(1, 0, 4'd7, 0, 1, acc);
        n = 0;
        for (int c = 0; c < 6; c++) begin
            if (rsp_valid && rsp_addr == 4'd7) n++;
            tick(0, 0, 0, 0, 1, acc);
        end
        chk("rst_new_rsp", 32'(n), 1);

        for (int c = 0; c < 600; c++)
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)),
                 8'($urandom), $urandom_range(0, 3) != 0, acc);
        for (int c = 0; c < 12; c++) tick(0, 0, 0, 0, 1, acc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
